pte_barrier_queue: RTL and testbench
====================================

# pte_barrier_queue

Parametrised, registered successor to the combinational PTE optimisation barrier. Holds up to DEPTH page-table-entry bundles (PPN plus D/A/G/U/X/W/R/V flags) in a ready/valid FIFO between the PTW response path and the TLB refill port. Optionally sanitises entries on dequeue and flags reserved permission encodings. Provides a synchronous flush for sfence/satp changes.

## Interface
- PPN_WIDTH, 54: width of the physical page number field.
- DEPTH, 2: number of entry slots; legal values are 1..16, and DEPTH does not need to be a power of two.
- PIPE, 1: when 1, enqueue is accepted while full if dequeue fires in the same cycle.
- SANITIZE, 1: when 1, enables output sanitising and fault detection on dequeue.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_flush  in  1  synchronous flush; empties the queue.
- io_enq_valid  in  1  producer has an entry.
- io_enq_ready  out  1  queue accepts an entry.
- io_enq_ppn  in  PPN_WIDTH  entry PPN.
- io_enq_flags  in  8  flags packed as {d,a,g,u,x,w,r,v}, with v in bit 0.
- io_deq_valid  out  1  head entry present.
- io_deq_ready  in  1  consumer takes the head entry.
- io_deq_ppn  out  PPN_WIDTH  head PPN, after sanitising.
- io_deq_flags  out  8  head flags, after sanitising.
- io_deq_fault  out  1  head entry has a reserved encoding; only meaningful when SANITIZE=1.
- io_count  out  clog2(DEPTH+1)  current occupancy.

## Operation
- Storage: DEPTH slots, head pointer, tail pointer and occupancy count. Pointers wrap from DEPTH-1 to 0.
- enq_fire = io_enq_valid & io_enq_ready. deq_fire = io_deq_valid & io_deq_ready.
- io_enq_ready = !io_flush & (count<DEPTH | (PIPE & io_deq_ready)).
- io_deq_valid = count!=0.
- On enq_fire: write the slot at tail, then advance tail.
- On deq_fire: advance head.
- Count update: +1 on enq only, -1 on deq only, unchanged when both fire or neither fires.
- When full with PIPE=1 and both fire, the write slot equals the freed head slot. The old head is presented this cycle; the new entry lands afterwards.
- Flush has priority over everything:
  - next state is head=tail=count=0; slot contents are don't-care;
  - enq is blocked through io_enq_ready=0;
  - a deq_fire in the flush cycle still hands the current head to the consumer.
- The queue never bypasses: an entry is visible on deq no earlier than the cycle after its enqueue.
- Sanitising, with SANITIZE=1, applied combinationally to the head slot:
  - v=0: io_deq_ppn=0, io_deq_flags=0, io_deq_fault=0.
  - v=1, w=1, r=0 (reserved): flags pass through with v forced to 0, ppn passes through, io_deq_fault=1.
  - Otherwise the entry passes through unchanged and io_deq_fault=0.
- With SANITIZE=0, the head slot passes through raw and io_deq_fault=0.
- When io_deq_valid=0, the deq data outputs show the head slot contents and are don't-care to the consumer. Io_deq_fault is forced to 0.

## Timing
- Reset (asynchronous assert, deassert sampled at clock): count=0, pointers=0, all slots=0. Outputs: io_deq_valid=0, io_enq_ready=1, io_count=0, io_deq_ppn=0, io_deq_flags=0, io_deq_fault=0.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Enqueue-to-dequeue latency is 1 cycle minimum.
- Sustained throughput is 1 entry/cycle when DEPTH>=2, or when DEPTH=1 with PIPE=1.
- io_enq_ready depends combinationally on io_deq_ready only when PIPE=1. The deq side is fully registered except for the sanitising logic.
- The valid/ready handshake follows these rules:
  - io_deq_valid does not drop without a deq_fire or a flush;
  - head data is stable while io_deq_valid=1 & !io_deq_ready.

## Test plan
- Reset then fill, DEPTH=2: enqueue ppn 0x111/flags 0x0F, then 0x222/0xCF → io_count 2, io_enq_ready=0 with io_deq_ready=0; dequeue order 0x111 then 0x222 with flags unchanged.
- PIPE full-throughput, DEPTH=2, PIPE=1: full queue, enq_valid=1 and deq_ready=1 for 10 cycles with ppn 1..10 → one entry out per cycle, io_count stays 2, order preserved. Repeat with PIPE=0 → enq_ready=0 whenever full.
- Wrap-around, DEPTH=3: 7 enq/deq pairs with ppn 0x10..0x16 → FIFO order correct across 2 pointer wraps.
- Sanitise: enqueue flags 0x00 with ppn 0xABC → deq ppn 0, flags 0. Enqueue flags 0x05 (w=1, r=0, v=1) → deq flags 0x04, fault=1. Enqueue flags 0x0B (x=1, r=1, v=1) → deq flags 0x0B, fault=0.
- Flush with simultaneous events: 2 entries held, assert io_flush together with enq_valid=1 and deq_ready=1. Required: enq_ready=0 in that cycle, the head is delivered, and the next cycle shows count=0 and deq_valid=0.
- Asynchronous reset mid-stream: assert reset between clock edges with 2 entries held → deq_valid=0 and count=0 before the next edge; after release, the queue accepts a new entry normally.

Source files
------------

// File: rtl/pte_barrier_queue.sv
// Purpose: registered FIFO of page-table entries between the PTW response path and the TLB refill port, with optional sanitising.
// Latency: an entry is visible on the dequeue side no earlier than one cycle after its enqueue; no bypass path.
// Backpressure: enqueue stalls when full, unless PIPE lets it through on a same-cycle dequeue; flush blocks enqueue.
module pte_barrier_queue #(
  parameter int PPN_WIDTH = 54,
  parameter int DEPTH     = 2,
  parameter int PIPE      = 1,
  parameter int SANITIZE  = 1,
  localparam int CW       = $clog2(DEPTH + 1),
  localparam int PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_flush,
  input  logic                 io_enq_valid,
  output logic                 io_enq_ready,
  input  logic [PPN_WIDTH-1:0] io_enq_ppn,
  input  logic [7:0]           io_enq_flags,
  output logic                 io_deq_valid,
  input  logic                 io_deq_ready,
  output logic [PPN_WIDTH-1:0] io_deq_ppn,
  output logic [7:0]           io_deq_flags,
  output logic                 io_deq_fault,
  output logic [CW-1:0]        io_count
);

  // One stored entry; flags are {d,a,g,u,x,w,r,v} with v in bit 0.
  typedef struct packed {
    logic [PPN_WIDTH-1:0] ppn;
    logic [7:0]           flags;
  } pte_t;

  pte_t          slot_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          enq_fire;
  logic          deq_fire;
  pte_t          head_ent;
  logic [PPN_WIDTH-1:0] san_ppn;
  logic [7:0]    san_flags;
  logic          san_fault;

  // Pointers wrap at DEPTH-1, so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full         = (count_q == CW'(DEPTH));
  // With PIPE, a full queue still accepts when the head leaves in the same cycle.
  assign io_enq_ready = !io_flush && (!full || ((PIPE != 0) && io_deq_ready));
  assign io_deq_valid = (count_q != '0);
  assign enq_fire     = io_enq_valid && io_enq_ready;
  assign deq_fire     = io_deq_valid && io_deq_ready;
  assign io_count     = count_q;

  // Next pointer/occupancy; flush overrides both handshakes.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (io_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = ptr_inc(tail_q);
      if (deq_fire) head_d = ptr_inc(head_q);
      if (enq_fire && !deq_fire) begin
        count_d = count_q + CW'(1);
      end else if (!enq_fire && deq_fire) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Pointer and occupancy registers; reset empties the queue without a clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Slot storage; when full with PIPE the write reuses the slot the head is vacating.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else if (enq_fire) begin
      slot_q[tail_q] <= '{ppn: io_enq_ppn, flags: io_enq_flags};
    end
  end

  // Output sanitising: invalid entries read as zero, write-without-read is reported and invalidated.
  always_comb begin
    head_ent  = slot_q[head_q];
    san_ppn   = head_ent.ppn;
    san_flags = head_ent.flags;
    san_fault = 1'b0;
    if (SANITIZE != 0) begin
      if (!head_ent.flags[0]) begin
        san_ppn   = '0;
        san_flags = '0;
      end else if (head_ent.flags[2] && !head_ent.flags[1]) begin
        san_flags[0] = 1'b0;
        san_fault    = 1'b1;
      end
    end
    io_deq_ppn   = san_ppn;
    io_deq_flags = san_flags;
    io_deq_fault = san_fault && io_deq_valid;
  end

endmodule

// File: tb/tb_pte_barrier_queue.sv
// Directed bench for pte_barrier_queue: three instances share stimulus
// (a: DEPTH=2 PIPE=1 SANITIZE=1, b: DEPTH=2 PIPE=0 SANITIZE=0, c: DEPTH=3 PIPE=1 SANITIZE=1).
// Inputs change on the falling edge; outputs are checked 1 ns later, well clear of the rising edge.
module tb_pte_barrier_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_flush;
  logic        io_enq_valid;
  logic [53:0] io_enq_ppn;
  logic [7:0]  io_enq_flags;
  logic        io_deq_ready;

  logic        a_enq_ready, a_deq_valid, a_deq_fault;
  logic [53:0] a_deq_ppn;
  logic [7:0]  a_deq_flags;
  logic [1:0]  a_count;
  logic        b_enq_ready, b_deq_valid, b_deq_fault;
  logic [53:0] b_deq_ppn;
  logic [7:0]  b_deq_flags;
  logic [1:0]  b_count;
  logic        c_enq_ready, c_deq_valid, c_deq_fault;
  logic [53:0] c_deq_ppn;
  logic [7:0]  c_deq_flags;
  logic [1:0]  c_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pte_barrier_queue #(.PPN_WIDTH(54), .DEPTH(2), .PIPE(1), .SANITIZE(1)) u_a (
    .clock(clock), .reset(reset), .io_flush(io_flush),
    .io_enq_valid(io_enq_valid), .io_enq_ready(a_enq_ready),
    .io_enq_ppn(io_enq_ppn), .io_enq_flags(io_enq_flags),
    .io_deq_valid(a_deq_valid), .io_deq_ready(io_deq_ready),
    .io_deq_ppn(a_deq_ppn), .io_deq_flags(a_deq_flags),
    .io_deq_fault(a_deq_fault), .io_count(a_count)
  );

  pte_barrier_queue #(.PPN_WIDTH(54), .DEPTH(2), .PIPE(0), .SANITIZE(0)) u_b (
    .clock(clock), .reset(reset), .io_flush(io_flush),
    .io_enq_valid(io_enq_valid), .io_enq_ready(b_enq_ready),
    .io_enq_ppn(io_enq_ppn), .io_enq_flags(io_enq_flags),
    .io_deq_valid(b_deq_valid), .io_deq_ready(io_deq_ready),
    .io_deq_ppn(b_deq_ppn), .io_deq_flags(b_deq_flags),
    .io_deq_fault(b_deq_fault), .io_count(b_count)
  );

  pte_barrier_queue #(.PPN_WIDTH(54), .DEPTH(3), .PIPE(1), .SANITIZE(1)) u_c (
    .clock(clock), .reset(reset), .io_flush(io_flush),
    .io_enq_valid(io_enq_valid), .io_enq_ready(c_enq_ready),
    .io_enq_ppn(io_enq_ppn), .io_enq_flags(io_enq_flags),
    .io_deq_valid(c_deq_valid), .io_deq_ready(io_deq_ready),
    .io_deq_ppn(c_deq_ppn), .io_deq_flags(c_deq_flags),
    .io_deq_fault(c_deq_fault), .io_count(c_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [53:0] p, input logic [7:0] f,
                       input logic dr, input logic fl);
    io_enq_valid = ev;
    io_enq_ppn   = p;
    io_enq_flags = f;
    io_deq_ready = dr;
    io_flush     = fl;
  endtask

  task automatic idle();
    drive(1'b0, 54'h0, 8'h00, 1'b0, 1'b0);
  endtask

  // Advance one rising edge and return on the following falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    tick();
    reset = 1'b1;
  endtask

  // Push two valid entries with deq_ready low; ends on a falling edge with inputs idle.
  task automatic fill2(input logic [53:0] p0, input logic [53:0] p1);
    drive(1'b1, p0, 8'h0F, 1'b0, 1'b0);
    tick();
    drive(1'b1, p1, 8'h0F, 1'b0, 1'b0);
    tick();
    idle();
  endtask

  // Enqueue one entry into an empty queue, then look at the dequeue side.
  task automatic san_case(input string tag, input logic [53:0] p, input logic [7:0] f,
                          input logic [53:0] exp_ppn, input logic [7:0] exp_flags,
                          input logic exp_fault);
    drive(1'b1, p, f, 1'b0, 1'b0);
    tick();
    idle();
    io_deq_ready = 1'b1;
    #1;
    check({tag, "_valid"}, a_deq_valid, 1'b1);
    check({tag, "_ppn"},   a_deq_ppn, exp_ppn);
    check({tag, "_flags"}, a_deq_flags, exp_flags);
    check({tag, "_fault"}, a_deq_fault, exp_fault);
    check({tag, "_raw_ppn"},   b_deq_ppn, p);
    check({tag, "_raw_flags"}, b_deq_flags, f);
    check({tag, "_raw_fault"}, b_deq_fault, 1'b0);
    tick();
    idle();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    #2;
    // Reset state
    check("rst_deq_valid", a_deq_valid, 1'b0);
    check("rst_enq_ready", a_enq_ready, 1'b1);
    check("rst_count",     a_count, 2'd0);
    check("rst_deq_ppn",   a_deq_ppn, 54'h0);
    check("rst_deq_flags", a_deq_flags, 8'h00);
    check("rst_deq_fault", a_deq_fault, 1'b0);
    check("rst_c_count",   c_count, 2'd0);
    @(negedge clock);
    reset = 1'b1;

    // Fill DEPTH=2 and drain in order
    drive(1'b1, 54'h111, 8'h0F, 1'b0, 1'b0);
    #1;
    check("fill_ready0", a_enq_ready, 1'b1);
    check("fill_nobypass", a_deq_valid, 1'b0);
    tick();
    drive(1'b1, 54'h222, 8'hCF, 1'b0, 1'b0);
    #1;
    check("fill_count1", a_count, 2'd1);
    check("fill_head1", a_deq_ppn, 54'h111);
    tick();
    idle();
    #1;
    check("fill_count2", a_count, 2'd2);
    check("fill_full_ready", a_enq_ready, 1'b0);
    check("fill_b_full_ready", b_enq_ready, 1'b0);
    io_deq_ready = 1'b1;
    #1;
    check("drain_ppn0", a_deq_ppn, 54'h111);
    check("drain_flags0", a_deq_flags, 8'h0F);
    tick();
    #1;
    check("drain_ppn1", a_deq_ppn, 54'h222);
    check("drain_flags1", a_deq_flags, 8'hCF);
    check("drain_count1", a_count, 2'd1);
    tick();
    idle();
    #1;
    check("drain_empty", a_deq_valid, 1'b0);
    check("drain_count0", a_count, 2'd0);

    // Full-throughput streaming: a (PIPE=1) vs b (PIPE=0)
    do_reset();
    fill2(54'hF1, 54'hF2);
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 54'(k), 8'h0F, 1'b1, 1'b0);
      #1;
      check($sformatf("pipe_a_ready_%0d", k), a_enq_ready, 1'b1);
      check($sformatf("pipe_a_count_%0d", k), a_count, 2'd2);
      check($sformatf("pipe_a_head_%0d", k), a_deq_ppn,
            (k <= 2) ? 54'(32'hF0 + k) : 54'(k - 2));
      if (k == 1) begin
        check("pipe_b_full_ready", b_enq_ready, 1'b0);
        check("pipe_b_head_1", b_deq_ppn, 54'hF1);
      end else begin
        check($sformatf("pipe_b_count_%0d", k), b_count, 2'd1);
        check($sformatf("pipe_b_head_%0d", k), b_deq_ppn,
              (k == 2) ? 54'hF2 : 54'(k - 1));
      end
      tick();
    end
    idle();

    // DEPTH=3 wrap-around across two pointer wraps
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 54'(32'h10 + i), 8'h0F, 1'b0, 1'b0);
      tick();
      drive(1'b0, 54'h0, 8'h00, 1'b1, 1'b0);
      #1;
      check($sformatf("wrap_head_%0d", i), c_deq_ppn, 54'(32'h10 + i));
      check($sformatf("wrap_count_%0d", i), c_count, 2'd1);
      tick();
      idle();
    end
    #1;
    check("wrap_empty", c_deq_valid, 1'b0);

    // Sanitising
    do_reset();
    san_case("san_inv",  54'hABC, 8'h00, 54'h0,   8'h00, 1'b0);
    san_case("san_wnr",  54'h5A5, 8'h05, 54'h5A5, 8'h04, 1'b1);
    san_case("san_xr",   54'h777, 8'h0B, 54'h777, 8'h0B, 1'b0);
    #1;
    check("san_fault_idle", a_deq_fault, 1'b0);

    // Flush with simultaneous enqueue and dequeue
    do_reset();
    fill2(54'h31, 54'h32);
    drive(1'b1, 54'h33, 8'h0F, 1'b1, 1'b1);
    #1;
    check("flush_enq_ready", a_enq_ready, 1'b0);
    check("flush_deq_valid", a_deq_valid, 1'b1);
    check("flush_head", a_deq_ppn, 54'h31);
    tick();
    idle();
    #1;
    check("flush_count", a_count, 2'd0);
    check("flush_empty", a_deq_valid, 1'b0);
    check("flush_ready_after", a_enq_ready, 1'b1);
    drive(1'b1, 54'h44, 8'h0F, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    check("flush_reuse_head", a_deq_ppn, 54'h44);
    check("flush_reuse_count", a_count, 2'd1);

    // Asynchronous reset between edges
    do_reset();
    fill2(54'h51, 54'h52);
    #1;
    check("arst_pre_count", a_count, 2'd2);
    reset = 1'b0;
    #1;
    check("arst_deq_valid", a_deq_valid, 1'b0);
    check("arst_count", a_count, 2'd0);
    check("arst_ppn", a_deq_ppn, 54'h0);
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, 54'h66, 8'h0F, 1'b0, 1'b0);
    #1;
    check("arst_enq_ready", a_enq_ready, 1'b1);
    tick();
    idle();
    #1;
    check("arst_new_count", a_count, 2'd1);
    check("arst_new_head", a_deq_ppn, 54'h66);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
